// File: rtl/gfx_pkg.sv
// Shared graphics types: pixel formats, pixel-arbiter FSM states and lane helpers.
// Lane helpers fold misaligned lane offsets back to lane 0 where the format cannot straddle.
package gfx_pkg;

    localparam int POINT_WIDTH   = 16;
    localparam int ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        BPP8  = 2'd0,
        BPP16 = 2'd1,
        BPP24 = 2'd2,
        BPP32 = 2'd3
    } color_depth_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        BUS  = 2'd2,
        DONE = 2'd3
    } pixarb_state_t;

    // 24-bit pixels occupy a full 32-bit slot.
    function automatic logic [2:0] bytes_per_pixel(color_depth_t depth);
        logic [2:0] bpp;
        case (depth)
            BPP8:    bpp = 3'd1;
            BPP16:   bpp = 3'd2;
            default: bpp = 3'd4;
        endcase
        return bpp;
    endfunction

    function automatic logic [3:0] lane_sel(color_depth_t depth, logic [1:0] b);
        logic [3:0] sel;
        case (depth)
            BPP8:    sel = 4'b0001 << b;
            BPP16:   sel = b[0] ? 4'b0011 : (4'b0011 << b);
            BPP24:   sel = 4'b0111;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lane_dat(color_depth_t depth, logic [31:0] c);
        logic [31:0] dat;
        case (depth)
            BPP8:    dat = {4{c[7:0]}};
            BPP16:   dat = {2{c[15:0]}};
            BPP24:   dat = {8'h00, c[23:0]};
            default: dat = c;
        endcase
        return dat;
    endfunction

endpackage

// File: rtl/gfx_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Latency: combinational. Backpressure: none; ce_i low forces an empty grant.
// Pointer state is owned by the instantiating module.
module gfx_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            ce_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    int          k;
    logic [IW-1:0] kidx;
    logic        found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        kidx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NREQ) k = k - NREQ;
            kidx = IW'(k);
            if (ce_i && !found && req_i[kidx]) begin
                found         = 1'b1;
                grant_o[kidx] = 1'b1;
                idx_o         = kidx;
            end
        end
    end

endmodule

// File: rtl/gfx_pixel_arbiter.sv
// Round-robin share of one 32-bit framebuffer write port; (x,y,colour) -> word address, lanes, data.
// Latency: req->ack_o in 4 cycles (IDLE, ADDR, BUS, DONE) with zero-wait m_ack_i; 1 pixel / 4 cycles.
// Backpressure: req_i held until ack_o; BUS waits on m_ack_i forever. GFX_CLIP_EN adds a clip rectangle.
module gfx_pixel_arbiter
    import gfx_pkg::*;
#(
    parameter int NREQ          = 3,
    parameter int point_width   = POINT_WIDTH,
    parameter int address_width = ADDRESS_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NREQ-1:0]             req_i,
    input  logic [NREQ*point_width-1:0] x_i,
    input  logic [NREQ*point_width-1:0] y_i,
    input  logic [NREQ*32-1:0]          color_i,
    output logic [NREQ-1:0]             ack_o,
    input  logic [address_width-1:0]    base_i,
    input  logic [point_width-1:0]      pitch_i,
    input  color_depth_t                depth_i,
`ifdef GFX_CLIP_EN
    input  logic [point_width-1:0]      clip_x0_i,
    input  logic [point_width-1:0]      clip_y0_i,
    input  logic [point_width-1:0]      clip_x1_i,
    input  logic [point_width-1:0]      clip_y1_i,
`endif
    output logic                        m_cyc_o,
    output logic                        m_we_o,
    output logic [address_width-1:0]    m_adr_o,
    output logic [3:0]                  m_sel_o,
    output logic [31:0]                 m_dat_o,
    input  logic                        m_ack_i,
    output logic                        busy_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    pixarb_state_t state_q, state_d;

    logic [IW-1:0]            ptr_q;
    logic [IW-1:0]            gidx_q;
    logic [NREQ-1:0]          gsel_q;
    logic [point_width-1:0]   x_q;
    logic [31:0]              col_q;
    logic [address_width-1:0] base_q;
    logic [address_width-1:0] row_q;
    color_depth_t             depth_q;

    logic [address_width-1:0] m_adr_q;
    logic [3:0]               m_sel_q;
    logic [31:0]              m_dat_q;

    logic [NREQ-1:0]          arb_gnt;
    logic [IW-1:0]            arb_idx;
    logic [point_width-1:0]   x_win;
    logic [point_width-1:0]   y_win;
    logic [31:0]              c_win;
    logic [address_width-1:0] adr_full;
    logic                     clip_out;

    gfx_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .ce_i    (state_q == IDLE),
        .grant_o (arb_gnt),
        .idx_o   (arb_idx)
    );

    assign x_win = x_i[arb_idx*point_width +: point_width];
    assign y_win = y_i[arb_idx*point_width +: point_width];
    assign c_win = color_i[arb_idx*32 +: 32];

    // The row product is registered at grant so ADDR only carries an add chain.
    assign adr_full = base_q + row_q
                    + address_width'(x_q) * address_width'(bytes_per_pixel(depth_q));

`ifdef GFX_CLIP_EN
    logic [point_width-1:0] y_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q <= '0;
        end else if (state_q == IDLE && |req_i) begin
            y_q <= y_win;
        end
    end

    assign clip_out = (x_q < clip_x0_i) || (x_q > clip_x1_i) ||
                      (y_q < clip_y0_i) || (y_q > clip_y1_i);
`else
    assign clip_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i) state_d = ADDR;
            ADDR:    state_d = clip_out ? DONE : BUS;
            BUS:     if (m_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gsel_q  <= '0;
            x_q     <= '0;
            col_q   <= '0;
            base_q  <= '0;
            row_q   <= '0;
            depth_q <= BPP8;
            m_adr_q <= '0;
            m_sel_q <= '0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        gidx_q  <= arb_idx;
                        gsel_q  <= arb_gnt;
                        x_q     <= x_win;
                        col_q   <= c_win;
                        base_q  <= base_i;
                        depth_q <= depth_i;
                        row_q   <= address_width'(y_win) * address_width'(pitch_i);
                    end
                end
                ADDR: begin
                    m_adr_q <= {adr_full[address_width-1:2], 2'b00};
                    m_sel_q <= lane_sel(depth_q, adr_full[1:0]);
                    m_dat_q <= lane_dat(depth_q, col_q);
                end
                DONE: begin
                    ptr_q <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Bus strobe and completion are state decodes so reset removes them without a clock.
    assign m_cyc_o = (state_q == BUS);
    assign m_we_o  = m_cyc_o;
    assign m_adr_o = m_adr_q;
    assign m_sel_o = m_sel_q;
    assign m_dat_o = m_dat_q;
    assign ack_o   = (state_q == DONE) ? gsel_q : '0;
    assign busy_o  = (state_q != IDLE);

endmodule
